ram_sp_ctrl: RTL and testbench

RAM_SP_CTRL -- requirements
Module: ram_sp_ctrl

---
 rtl/ram_sp_pkg.sv | 15 +
 rtl/ram_sp_ar_sw.sv | 27 ++
 rtl/ram_sp_ctrl.sv | 112 +++++++++++
 tb/tb_ram_sp_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sp_pkg.sv
// Shared definitions for the single-port RAM controller: FSM state encoding
// and default bus widths.
package ram_sp_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int AWIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_sp_ar_sw.sv
// Single-port RAM model: asynchronous read onto a shared tristate data bus,
// synchronous write on the rising clock edge.
module ram_sp_ar_sw
    import ram_sp_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic [AWIDTH-1:0] address,
    inout  wire  [DWIDTH-1:0] data,
    input  logic              cs,
    input  logic              we,
    input  logic              oe
);

    logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

    assign data = (cs && oe && !we) ? mem[address] : {DWIDTH{1'bz}};

    always_ff @(posedge clk) begin
        if (cs && we) begin
            mem[address] <= data;
        end
    end

endmodule

// File: rtl/ram_sp_ctrl.sv
// Request/response front end for a single-port RAM with a shared tristate data
// bus. Every output is a register, so RAM strobes lag the FSM state by one edge.
module ram_sp_ctrl
    import ram_sp_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic [AWIDTH-1:0] ram_address,
    inout  wire  [DWIDTH-1:0] ram_data,
    output logic              ram_cs,
    output logic              ram_oe,
    output logic              ram_we
);

    state_e            state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DWIDTH-1:0] rsp_rdata_q;
    logic [AWIDTH-1:0] ram_address_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              ram_cs_q;
    logic              ram_oe_q;
    logic              ram_we_q;
    logic              accept;

    // req_ready_q is only ever set while in IDLE, so it doubles as the state qualifier
    assign accept = req_valid && req_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            ram_address_q <= '0;
            ram_cs_q      <= 1'b0;
            ram_oe_q      <= 1'b0;
            ram_we_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ram_cs_q <= 1'b0;
                    ram_oe_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    if (accept) begin
                        req_ready_q   <= 1'b0;
                        ram_address_q <= req_addr;
                        state_q       <= req_we ? WRITE : READ;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WRITE: begin
                    ram_cs_q <= 1'b1;
                    ram_we_q <= 1'b1;
                    ram_oe_q <= 1'b0;
                    state_q  <= IDLE;
                end
                READ: begin
                    ram_cs_q <= 1'b1;
                    ram_oe_q <= 1'b1;
                    ram_we_q <= 1'b0;
                    state_q  <= RESP;
                end
                RESP: begin
                    ram_cs_q <= 1'b0;
                    ram_oe_q <= 1'b0;
                    // First RESP edge closes the RAM read cycle; hold the data afterwards
                    if (!rsp_valid_q) begin
                        rsp_rdata_q <= ram_data;
                        rsp_valid_q <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_q <= req_wdata;
        end
    end

    // Bus is driven only while the write strobe is up, leaving Z on both sides
    assign ram_data    = ram_we_q ? wdata_q : {DWIDTH{1'bz}};

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign ram_address = ram_address_q;
    assign ram_cs      = ram_cs_q;
    assign ram_oe      = ram_oe_q;
    assign ram_we      = ram_we_q;

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Scoreboard bench for ram_sp_ctrl with the ram_sp_ar_sw RAM model on the bus.
module tb_ram_sp_ctrl;
    import ram_sp_pkg::*;

    localparam int DW    = DWIDTH_DEF;
    localparam int AW    = AWIDTH_DEF;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_address;
    wire  [DW-1:0] ram_data;
    logic          ram_cs;
    logic          ram_oe;
    logic          ram_we;

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    bit            rand_rdy = 1'b0;
    bit            rdy_force = 1'b1;

    // Reference model: plain memory image plus expected-response queue
    logic [DW-1:0] mem_m [DEPTH];
    bit            known [DEPTH];
    int            known_list[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_wdata = '0;

    always #5 clk = ~clk;

    // Weak stand-in for "nobody drives": when the RAM is deselected the bench
    // puts zero on the bus, so any stray controller drive shows up as nonzero.
    assign ram_data = ram_cs ? {DW{1'bz}} : {DW{1'b0}};

    ram_sp_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_cs      (ram_cs),
        .ram_oe      (ram_oe),
        .ram_we      (ram_we)
    );

    ram_sp_ar_sw #(.DWIDTH(DW), .AWIDTH(AW)) u_ram (
        .clk     (clk),
        .address (ram_address),
        .data    (ram_data),
        .cs      (ram_cs),
        .we      (ram_we),
        .oe      (ram_oe)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_line(input string nm, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0h (cycle %0d)", nm, act, cyc);
    endtask

    task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit hold, input bit push, output int acc);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        acc = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            fail_line("req_accept_timeout", {31'd0, req_ready});
            req_valid = 1'b0;
        end else begin
            if (!hold) req_valid = 1'b0;
            if (we) begin
                mem_m[a]   = d;
                last_wdata = d;
                if (!known[a]) known_list.push_back(int'(a));
                known[a] = 1'b1;
            end else if (push) begin
                exp_q.push_back(mem_m[a]);
            end
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_line(nm, exp_q.size());
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor: response scoreboard, hold-stability and bus ownership checks
    initial begin
        logic [DW-1:0] prev_data;
        bit            prev_pend;
        prev_pend = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
                    chk("rsp_hold_data", rsp_rdata, prev_data);
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) fail_line("rsp_unexpected", rsp_rdata);
                    else chk("rsp_data", rsp_rdata, exp_q.pop_front());
                end
                prev_pend = rsp_valid && !rsp_ready;
                prev_data = rsp_rdata;
                if (ram_we) begin
                    chk("bus_wr_data", ram_data, last_wdata);
                    chk("bus_wr_strobes", {30'd0, ram_cs, ram_oe}, 32'd2);
                end
                if (!ram_cs) begin
                    chk("bus_idle", ram_data, 32'd0);
                    chk("idle_strobes", {30'd0, ram_oe, ram_we}, 32'd0);
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3;
        int wait_n;
        bit we;
        bit hold;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", {31'd0, ram_cs}, 32'd0);
        chk("rst_oe", {31'd0, ram_oe}, 32'd0);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_address", ram_address, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_bus_z", ram_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Write 0x12 = 0xA5 with latency checks
        do_req(1'b1, 8'h12, 8'hA5, 1'b0, 1'b0, a1);
        @(negedge clk);
        chk("wr_n0_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("wr_n1_strobes", {29'd0, ram_cs, ram_oe, ram_we}, 32'd5);
        chk("wr_n1_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("wr_n2_ready", {31'd0, req_ready}, 32'd1);
        chk("wr_n2_cs", {31'd0, ram_cs}, 32'd0);
        @(posedge clk);
        #1;

        // Read 0x12 with latency checks
        do_req(1'b0, 8'h12, 8'h00, 1'b0, 1'b1, a1);
        @(negedge clk);
        chk("rd_n0_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rd_n1_strobes", {29'd0, ram_cs, ram_oe, ram_we}, 32'd6);
        chk("rd_n1_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rd_n2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_n2_data", rsp_rdata, 32'hA5);
        @(negedge clk);
        chk("rd_n3_valid", {31'd0, rsp_valid}, 32'd0);
        drain("rd_drain");
        @(posedge clk);
        #1;

        // Back-to-back requests with req_valid held high
        do_req(1'b1, 8'h00, 8'h11, 1'b1, 1'b0, a1);
        do_req(1'b1, 8'hFF, 8'h22, 1'b1, 1'b0, a2);
        do_req(1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, a3);
        chk("b2b_gap_wr_wr", a2 - a1, 32'd3);
        chk("b2b_gap_wr_rd", a3 - a2, 32'd3);
        drain("b2b_drain");
        @(posedge clk);
        #1;

        // Read 0x12 with consumer stalling for 5 cycles
        rdy_force = 1'b0;
        @(posedge clk);
        #2;
        do_req(1'b0, 8'h12, 8'h00, 1'b0, 1'b1, a1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_data", rsp_rdata, 32'hA5);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rdy_force = 1'b1;
        wait_n = 0;
        while (req_ready !== 1'b1 && wait_n < 8) begin
            @(negedge clk);
            wait_n++;
        end
        chk("stall_back_to_idle", {31'd0, req_ready}, 32'd1);
        drain("stall_drain");
        @(posedge clk);
        #1;

        // Reset pulse during the RAM read cycle
        do_req(1'b0, 8'h12, 8'h00, 1'b0, 1'b0, a1);
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_cs", {31'd0, ram_cs}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_cs_now", {31'd0, ram_cs}, 32'd0);
        chk("abort_oe_now", {31'd0, ram_oe}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        do_req(1'b0, 8'h12, 8'h00, 1'b0, 1'b1, a1);
        drain("abort_reread_drain");
        @(posedge clk);
        #1;

        // Randomized traffic with a randomly stalling consumer
        rand_rdy = 1'b1;
        for (int k = 0; k < 150; k++) begin
            we   = 1'($urandom_range(0, 1));
            a    = AW'($urandom_range(0, DEPTH - 1));
            d    = DW'($urandom);
            hold = 1'($urandom_range(0, 1));
            if (!we && !known[a]) a = AW'(known_list[$urandom_range(0, known_list.size() - 1)]);
            do_req(we, a, d, hold, 1'b1, a1);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        rand_rdy  = 1'b0;
        rdy_force = 1'b1;
        drain("rand_drain");
        repeat (4) @(negedge clk);
        chk("end_cs", {31'd0, ram_cs}, 32'd0);
        chk("end_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
